// File: rtl/vector_stream_port_if.sv
// Host/bank-side bus bundle for vector_stream_port: command, write/read streams and bank strobes.
// master = the port itself, slave = the host/bank environment driving it.
interface vector_stream_port_if #(
  parameter int BITS = 8,
  parameter int N    = 64,
  parameter int NREG = 4,
  parameter int RW   = (NREG > 1) ? $clog2(NREG) : 1
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_wr;
  logic [RW-1:0]   cmd_reg;
  logic [BITS-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic [BITS-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic [BITS-1:0] vec_out [N-1:0];
  logic [NREG-1:0] vec_set;
  logic [BITS-1:0] vec_in  [N-1:0];
  logic [NREG-1:0] vec_en;
  logic            busy;

  modport master (
    input  cmd_valid, cmd_wr, cmd_reg, s_data, s_valid, m_ready, vec_in,
    output cmd_ready, s_ready, m_data, m_valid, vec_out, vec_set, vec_en, busy
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_reg, s_data, s_valid, m_ready, vec_in,
    input  cmd_ready, s_ready, m_data, m_valid, vec_out, vec_set, vec_en, busy
  );
endinterface

// File: rtl/vector_stream_port.sv
// Stream <-> vector-register-bank bridge: LOAD/COMMIT writes a register, FETCH/STREAM reads one.
// Optional feature macro VSP_ABORT_EN adds an abort input that cancels an in-flight sequence.

// One buffer element; a bank capture always wins over a stream write.
module vsp_lane #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [BITS-1:0] load_data,
  input  logic            cap,
  input  logic [BITS-1:0] cap_data,
  output logic [BITS-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (cap)  q <= cap_data;
    else if (load) q <= load_data;
  end
endmodule

module vector_stream_port #(
  parameter int BITS = 8,
  parameter int N    = 64,
  parameter int NREG = 4,
  parameter int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef VSP_ABORT_EN
  input  logic abort,
`endif
  vector_stream_port_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, FETCH, STREAM} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [RW-1:0]          reg_q;
  logic                   s_ready_q;
  logic                   m_valid_q;
  logic                   busy_q;
  logic [NREG-1:0]        set_q;
  logic [NREG-1:0]        en_q;
  logic [N-1:0][BITS-1:0] buf_q;

  logic abort_i;
  logic last;
  logic reg_ok;
  logic wr_hs;
  logic rd_hs;
  logic cap;

`ifdef VSP_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Out-of-range register indices decode to an all-zero strobe.
  function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] r);
    onehot = '0;
    for (int k = 0; k < NREG; k++)
      if (int'(r) == k) onehot[k] = 1'b1;
  endfunction

  assign last   = (idx == IW'(N-1));
  assign reg_ok = (int'(reg_q) < NREG);
  // Abort beats a same-cycle data handshake, so the element is never counted.
  assign wr_hs  = (state == LOAD)   && bus.s_valid && !abort_i;
  assign rd_hs  = (state == STREAM) && bus.m_ready && !abort_i;
  assign cap    = (state == FETCH)  && !abort_i;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      vsp_lane #(.BITS(BITS)) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wr_hs && (idx == IW'(gi))),
        .load_data(bus.s_data),
        .cap      (cap),
        .cap_data (reg_ok ? bus.vec_in[gi] : '0),
        .q        (buf_q[gi])
      );
      assign bus.vec_out[gi] = buf_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      reg_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      set_q     <= '0;
      en_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            reg_q  <= bus.cmd_reg;
            idx    <= '0;
            busy_q <= 1'b1;
            if (bus.cmd_wr) begin
              state     <= LOAD;
              s_ready_q <= 1'b1;
            end else begin
              state <= FETCH;
              en_q  <= onehot(bus.cmd_reg);
            end
          end
        end
        LOAD: begin
          if (abort_i) begin
            state     <= IDLE;
            idx       <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (wr_hs) begin
            if (last) begin
              state     <= COMMIT;
              idx       <= '0;
              s_ready_q <= 1'b0;
              set_q     <= onehot(reg_q);
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        // COMMIT ignores abort: the strobe always completes its single cycle.
        COMMIT: begin
          state  <= IDLE;
          set_q  <= '0;
          busy_q <= 1'b0;
        end
        FETCH: begin
          en_q <= '0;
          if (abort_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state     <= STREAM;
            m_valid_q <= 1'b1;
          end
        end
        STREAM: begin
          if (abort_i || (rd_hs && last)) begin
            state     <= IDLE;
            idx       <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (rd_hs) begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          set_q     <= '0;
          en_q      <= '0;
        end
      endcase
    end
  end

  // cmd_ready is gated by rst_n so it reads 0 while reset is held.
  assign bus.cmd_ready = rst_n && (state == IDLE);
  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_valid_q ? buf_q[idx] : '0;
  assign bus.vec_set   = set_q;
  assign bus.vec_en    = en_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_vector_stream_port.sv
// Directed bench for vector_stream_port: reset, writes, stalled read, invalid register, mid-op reset.
module tb_vector_stream_port;
  localparam int BITS = 8;
  localparam int N    = 64;
  localparam int NREG = 4;
  localparam int RW   = 3;

  logic clk = 1'b0;
  logic rst_n;
`ifdef VSP_ABORT_EN
  logic abort;
`endif
  int checks   = 0;
  int failures = 0;
  int set_pulses = 0;
  int en_pulses  = 0;
  int overlap    = 0;

  always #5 clk = ~clk;

  vector_stream_port_if #(.BITS(BITS), .N(N), .NREG(NREG), .RW(RW)) vif ();

  vector_stream_port #(.BITS(BITS), .N(N), .NREG(NREG), .RW(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef VSP_ABORT_EN
    .abort(abort),
`endif
    .bus  (vif.master)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (|vif.vec_set) set_pulses++;
      if (|vif.vec_en)  en_pulses++;
      if ((|vif.vec_set && |vif.vec_en) || $countones(vif.vec_set) > 1 ||
          $countones(vif.vec_en) > 1) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [RW-1:0] r);
    vif.cmd_valid = 1'b1;
    vif.cmd_wr    = wr;
    vif.cmd_reg   = r;
    step();
    vif.cmd_valid = 1'b0;
  endtask

  initial begin
    int p0, e0, acc, errs, stall_errs, nz, hs;
    logic took;
    logic [7:0] exp;

    rst_n = 1'b1;
`ifdef VSP_ABORT_EN
    abort = 1'b0;
`endif
    vif.cmd_valid = 1'b0; vif.cmd_wr = 1'b0; vif.cmd_reg = '0;
    vif.s_data = '0; vif.s_valid = 1'b0; vif.m_ready = 1'b0;
    for (int i = 0; i < N; i++) vif.vec_in[i] = '0;

    // 1. asynchronous reset mid-clock
    #3 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", vif.cmd_ready, 0);
    chk("rst_busy", vif.busy, 0);
    chk("rst_strobes", {vif.vec_set, vif.vec_en}, 0);
    chk("rst_streams", {vif.m_valid, vif.s_ready, vif.m_data}, 0);
    chk("rst_vec_out", vif.vec_out[N-1], 0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", vif.cmd_ready, 1);
    chk("rel_busy", vif.busy, 0);
    step();

    // 2. write reg 2, back-to-back elements 0..N-1
    issue(1'b1, 3'd2);
    chk("wr_busy", vif.busy, 1);
    chk("wr_s_ready", vif.s_ready, 1);
    chk("wr_cmd_ready", vif.cmd_ready, 0);
    p0 = set_pulses;
    for (int i = 0; i < N; i++) begin
      vif.s_valid = 1'b1;
      vif.s_data  = 8'(i);
      step();
    end
    vif.s_valid = 1'b0;
    chk("wr_vec_set", vif.vec_set, 4'b0100);
    chk("wr_s_ready_off", vif.s_ready, 0);
    errs = 0;
    for (int i = 0; i < N; i++) if (vif.vec_out[i] !== 8'(i)) errs++;
    chk("wr_order", errs, 0);
    step();
    chk("wr_set_clear", vif.vec_set, 0);
    chk("wr_idle", {vif.cmd_ready, vif.busy}, 2'b10);
    chk("wr_pulses", set_pulses - p0, 1);

    // 3. write reg 0 with s_valid toggling
    issue(1'b1, 3'd0);
    p0 = set_pulses;
    acc = 0;
    for (int c = 0; c < 4*N && acc < N; c++) begin
      vif.s_valid = ~c[0];
      vif.s_data  = 8'(8'h80 + acc);
      took = vif.s_valid && vif.s_ready;
      step();
      if (took) acc++;
    end
    vif.s_valid = 1'b0;
    chk("tog_accepts", acc, N);
    chk("tog_vec_set", vif.vec_set, 4'b0001);
    errs = 0;
    for (int i = 0; i < N; i++) if (vif.vec_out[i] !== 8'(8'h80 + i)) errs++;
    chk("tog_order", errs, 0);
    step();
    chk("tog_pulses", set_pulses - p0, 1);

    // 4. read reg 1 with 3-cycle stalls per element
    for (int i = 0; i < N; i++) vif.vec_in[i] = 8'(8'hA0 + i);
    e0 = en_pulses;
    issue(1'b0, 3'd1);
    chk("rd_vec_en", vif.vec_en, 4'b0010);
    chk("rd_fetch_mvalid", vif.m_valid, 0);
    step();
    for (int i = 0; i < N; i++) vif.vec_in[i] = 8'h11;
    chk("rd_en_clear", vif.vec_en, 0);
    chk("rd_first", {vif.m_valid, vif.m_data}, {1'b1, 8'hA0});
    errs = 0; stall_errs = 0;
    for (int e = 0; e < N; e++) begin
      exp = 8'(8'hA0 + e);
      if (vif.m_data !== exp || vif.m_valid !== 1'b1) errs++;
      vif.m_ready = 1'b0;
      repeat (3) begin
        step();
        if (vif.m_data !== exp || vif.m_valid !== 1'b1) stall_errs++;
      end
      vif.m_ready = 1'b1;
      step();
    end
    vif.m_ready = 1'b0;
    chk("rd_data", errs, 0);
    chk("rd_stall_hold", stall_errs, 0);
    chk("rd_done", {vif.m_valid, vif.cmd_ready, vif.busy}, 3'b010);
    chk("rd_en_pulses", en_pulses - e0, 1);

    // 5. invalid register 5: write then read
    p0 = set_pulses; e0 = en_pulses;
    issue(1'b1, 3'd5);
    for (int i = 0; i < N; i++) begin
      vif.s_valid = 1'b1;
      vif.s_data  = 8'hFF;
      step();
    end
    vif.s_valid = 1'b0;
    chk("inv_wr_commit", {vif.busy, vif.vec_set}, {1'b1, 4'b0000});
    step();
    chk("inv_wr_idle", vif.cmd_ready, 1);
    chk("inv_wr_pulses", set_pulses - p0, 0);
    for (int i = 0; i < N; i++) vif.vec_in[i] = 8'h5A;
    issue(1'b0, 3'd5);
    chk("inv_rd_fetch", {vif.busy, vif.vec_en}, {1'b1, 4'b0000});
    step();
    vif.m_ready = 1'b1;
    nz = 0; hs = 0;
    for (int c = 0; c < N + 4 && vif.m_valid === 1'b1; c++) begin
      if (vif.m_data !== 8'h00) nz++;
      hs++;
      step();
    end
    vif.m_ready = 1'b0;
    chk("inv_rd_zeros", nz, 0);
    chk("inv_rd_count", hs, N);
    chk("inv_rd_en_pulses", en_pulses - e0, 0);

    // mid-operation reset during a write
    p0 = set_pulses;
    issue(1'b1, 3'd3);
    for (int i = 0; i < 5; i++) begin
      vif.s_valid = 1'b1;
      vif.s_data  = 8'h33;
      step();
    end
    vif.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {vif.busy, vif.s_ready, vif.cmd_ready, vif.vec_set}, 0);
    chk("mid_rst_buf", vif.vec_out[0], 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rel", vif.cmd_ready, 1);
    chk("mid_rst_pulses", set_pulses - p0, 0);
    step();

`ifdef VSP_ABORT_EN
    // 6. abort after 10 elements, then a clean write
    p0 = set_pulses;
    issue(1'b1, 3'd3);
    for (int i = 0; i < 10; i++) begin
      vif.s_valid = 1'b1;
      vif.s_data  = 8'(i + 1);
      step();
    end
    abort = 1'b1;
    vif.s_data = 8'hEE;
    step();
    abort = 1'b0;
    vif.s_valid = 1'b0;
    chk("abt_idle", {vif.busy, vif.cmd_ready, vif.s_ready}, 3'b010);
    chk("abt_elem_dropped", vif.vec_out[10], 0);
    step();
    chk("abt_no_set", set_pulses - p0, 0);
    issue(1'b1, 3'd3);
    for (int i = 0; i < N; i++) begin
      vif.s_valid = 1'b1;
      vif.s_data  = 8'(8'h10 + i);
      step();
    end
    vif.s_valid = 1'b0;
    chk("abt_next_set", vif.vec_set, 4'b1000);
    chk("abt_next_data", vif.vec_out[0], 8'h10);
    step();
    chk("abt_next_pulses", set_pulses - p0, 1);
`endif

    chk("strobe_exclusive", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
